bcd_countdown: RTL and testbench
================================

Name: bcd_countdown

Overview:
- Downstream consumer of the two-digit entry validator.
- Loads the accepted BCD minutes/seconds value (tens, ones) when the validator asserts its start-permission level, then counts it down once per second to 00.
- Drives the live digit display, running/paused status, and a timed alarm output at expiry.
- Supports pause/resume and cancel from front-panel pulses.

Parameters:
- TICKS_PER_SEC, 100000000, clk cycles per one-second decrement (>=2).
- ALARM_SEC, 3, seconds the alarm output stays high after expiry (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- allow_start  in  1  level from validator, asynchronous to clk; a rising edge requests load+start.
- ld_tens  in  4  BCD tens digit from validator; stable while allow_start high.
- ld_ones  in  4  BCD ones digit from validator; stable while allow_start high.
- pause_req  in  1  one-clk pulse, toggles RUN<->PAUSE.
- cancel  in  1  one-clk pulse, abort to IDLE.
- cnt_tens  out  4  current tens digit.
- cnt_ones  out  4  current ones digit.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- done  out  1  one-clk pulse on reaching 00.
- alarm  out  1  high in ALARM.

Behaviour:
- Reset: all outputs 0, state IDLE, prescaler 0, synchronizer flops 0.
- allow_start is passed through a 2-flop synchronizer plus edge detector, giving start_p. Latency is 3 clk from the input edge to start_p.
- States: IDLE, RUN, PAUSE, ALARM.
- Priority per cycle: cancel > start_p > pause_req > sec tick.
- start_p handling:
  - Accepted in any state: capture ld_tens/ld_ones into cnt_*, clear prescaler, go to RUN.
  - Ignored, with no state change, if either digit > 9 or the value is 00.
  - start_p in RUN/PAUSE/ALARM restarts with the new value; alarm drops in that cycle.
- cancel: cnt_* cleared to 0, prescaler cleared, go to IDLE, alarm 0. No done pulse.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 only in RUN (and ALARM, for alarm timing).
  - Tick fires when it wraps.
  - Holds its value in PAUSE, so a resumed second is completed, not restarted.
- RUN on tick: BCD decrement.
  - ones>0: ones-1.
  - ones==0, tens>0: ones=9, tens-1.
  - Both 0 cannot occur in RUN.
- When the decrement produces 00:
  - done=1 for exactly that cycle.
  - Go to ALARM, load alarm second counter = ALARM_SEC.
  - First full second starts with the prescaler at 0.
- pause_req: RUN->PAUSE, PAUSE->RUN; ignored in IDLE/ALARM.
- ALARM:
  - alarm=1.
  - Each tick decrements the alarm counter; at 0 go to IDLE, alarm=0.
  - cnt_* stay 00 throughout.
- Simultaneous events:
  - pause_req and tick in the same cycle: pause wins, no decrement.
  - cancel together with start_p: cancel wins; the start is lost.
- Reset mid-count forces IDLE immediately (asynchronous), regardless of state.
- Output registers:
  - running, paused and alarm are registered decodes of state, updating in the same edge as the state.
  - cnt_* are registered.

Decomposition:
- Package bcd_countdown_pkg holds:
  - state enum {ST_IDLE, ST_RUN, ST_PAUSE, ST_ALARM}.
  - BCD digit typedef (4-bit).
  - Constant BCD_MAX=9.
- One sub-module, sec_prescaler.
  - Ports: clk, reset, clr, en; output tick.
  - Behaviour: one-clk pulse every TICKS_PER_SEC enabled cycles; holds count when en=0.
- Synchronizer and BCD decrement stay inline.

Test Plan (TICKS_PER_SEC=4, ALARM_SEC=2):
- Basic countdown: ld=1,2, allow_start rises.
  - RUN and cnt=12 on the 3rd clk after the edge.
  - cnt=11 four clks later, then 10.
  - Then 09 (tens borrow).
  - ... 00 with done pulse on the 48th clk after load.
- Alarm timing: continue the basic countdown.
  - alarm high 8 clks, then IDLE.
  - alarm=0, cnt=00, done pulsed once only.
- Pause: load 05; after 6 clks pause_req; hold 20 clks; pause_req again.
  - cnt frozen at 04 while paused, paused=1.
  - After resume, 04->03 occurs 2 clks later (prescaler preserved).
- Invalid/zero load:
  - ld=0,0 then ld=1,10 with allow_start edges: both ignored, state IDLE, cnt=00.
  - Then ld=0,3: loads 03.
- Cancel/restart priority:
  - In RUN at 07, assert cancel and start_p the same cycle -> IDLE, cnt=00.
  - Next: start at 20 while in ALARM -> alarm drops, RUN, cnt=20.
- Async reset: assert reset mid-RUN between clock edges.
  - All outputs 0 immediately.
  - After release, an allow_start level already high does not produce start_p until it falls and rises again.

Source files
------------

// File: rtl/bcd_countdown_pkg.sv
// bcd_countdown_pkg: shared state encoding and BCD digit types for the countdown timer
package bcd_countdown_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_ALARM} state_e;
    typedef logic [3:0] bcd_t;
    localparam bcd_t BCD_MAX = 4'd9;
endpackage

// File: rtl/sec_prescaler.sv
// sec_prescaler: one-clk tick every TICKS_PER_SEC enabled cycles, count held while disabled
module sec_prescaler #(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int W = $clog2(TICKS_PER_SEC);
    logic [W-1:0] cnt_q, cnt_d;
    assign tick = en && cnt_q == W'(TICKS_PER_SEC - 1);
    always_comb cnt_d = (clr || tick) ? '0 : en ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
endmodule

// File: rtl/bcd_countdown.sv
// bcd_countdown: loads a validated BCD mm/ss value, counts it down once per second and raises a timed alarm
module bcd_countdown
    import bcd_countdown_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int ALARM_SEC     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       allow_start,
    input  logic [3:0] ld_tens,
    input  logic [3:0] ld_ones,
    input  logic       pause_req,
    input  logic       cancel,
    output logic [3:0] cnt_tens,
    output logic [3:0] cnt_ones,
    output logic       running,
    output logic       paused,
    output logic       done,
    output logic       alarm
);
    localparam int AW = $clog2(ALARM_SEC + 1);
    state_e        state_q, state_d;
    bcd_t          tens_q, tens_d, ones_q, ones_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic          done_q, done_d, running_q, paused_q, alarm_q;
    logic [2:0]    sync_q;
    logic [1:0]    vld_q;
    logic          armed_q, start_p, take, tick;
    // armed only after a genuine low level has been synchronized, so a level already high at reset release never starts
    assign start_p = sync_q[1] && !sync_q[2] && armed_q;
    assign take    = start_p && ld_tens <= BCD_MAX && ld_ones <= BCD_MAX && {ld_tens, ld_ones} != 8'h00;
    sec_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_pre (
        .clk   (clk),
        .reset (reset),
        .clr   (cancel || take),
        .en    (state_q == ST_RUN || state_q == ST_ALARM),
        .tick  (tick)
    );
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        acnt_d  = acnt_q;
        done_d  = 1'b0;
        if (cancel) begin
            state_d = ST_IDLE;
            tens_d  = '0;
            ones_d  = '0;
        end else if (take) begin
            state_d = ST_RUN;
            tens_d  = ld_tens;
            ones_d  = ld_ones;
        end else if (pause_req && (state_q == ST_RUN || state_q == ST_PAUSE)) begin
            state_d = state_q == ST_RUN ? ST_PAUSE : ST_RUN;
        end else if (tick && state_q == ST_RUN) begin
            ones_d = ones_q != '0 ? ones_q - 4'd1 : BCD_MAX;
            tens_d = ones_q != '0 ? tens_q : tens_q - 4'd1;
            if (tens_q == '0 && ones_q == 4'd1) begin
                state_d = ST_ALARM;
                done_d  = 1'b1;
                acnt_d  = AW'(ALARM_SEC);
            end
        end else if (tick && state_q == ST_ALARM) begin
            acnt_d  = acnt_q - AW'(1);
            state_d = acnt_q == AW'(1) ? ST_IDLE : ST_ALARM;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tens_q    <= '0;
            ones_q    <= '0;
            acnt_q    <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            alarm_q   <= 1'b0;
            sync_q    <= '0;
            vld_q     <= '0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            acnt_q    <= acnt_d;
            done_q    <= done_d;
            running_q <= state_d == ST_RUN;
            paused_q  <= state_d == ST_PAUSE;
            alarm_q   <= state_d == ST_ALARM;
            sync_q    <= {sync_q[1:0], allow_start};
            vld_q     <= {vld_q[0], 1'b1};
            armed_q   <= armed_q || (vld_q[1] && !sync_q[1]);
        end
    end
    assign cnt_tens = tens_q;
    assign cnt_ones = ones_q;
    assign running  = running_q;
    assign paused   = paused_q;
    assign done     = done_q;
    assign alarm    = alarm_q;
endmodule

// File: tb/tb_bcd_countdown.sv
// tb_bcd_countdown: scoreboard bench; stimulus queues cycle-stamped expectations, a negedge monitor compares them
module tb_bcd_countdown;
    logic       clk = 1'b0, reset = 1'b1, allow_start = 1'b0, pause_req = 1'b0, cancel = 1'b0;
    logic [3:0] ld_tens = '0, ld_ones = '0, cnt_tens, cnt_ones;
    logic       running, paused, done, alarm;
    int         cyc = 0, n_chk = 0, n_fail = 0, done_cnt = 0;

    typedef struct {
        int          at;
        string       name;
        logic [11:0] v;
    } exp_t;
    exp_t sb[$];

    bcd_countdown #(.TICKS_PER_SEC(4), .ALARM_SEC(2)) dut (
        .clk(clk), .reset(reset), .allow_start(allow_start), .ld_tens(ld_tens), .ld_ones(ld_ones),
        .pause_req(pause_req), .cancel(cancel), .cnt_tens(cnt_tens), .cnt_ones(cnt_ones),
        .running(running), .paused(paused), .done(done), .alarm(alarm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [11:0] got, logic [11:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got {tens,ones,run,pau,done,alm}=%h_%h_%b, expected %h_%h_%b",
                     name, cyc, got[11:8], got[7:4], got[3:0], want[11:8], want[7:4], want[3:0]);
        end
    endtask

    // flags = {running, paused, done, alarm}
    task automatic exp(int at, string name, logic [3:0] t, logic [3:0] o, logic [3:0] flags);
        sb.push_back('{at, name, {t, o, flags}});
    endtask

    task automatic go(int c);
        while (cyc != c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                check(sb[i].name, {cnt_tens, cnt_ones, running, paused, done, alarm}, sb[i].v);
                sb.delete(i);
            end else if (sb[i].at < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s: expectation for cyc %0d never sampled", sb[i].name, sb[i].at);
                sb.delete(i);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp(4, "reset_state", 4'h0, 4'h0, 4'b0000);
        go(5);
        reset = 1'b0;
        // basic countdown from 12 through alarm
        go(10);
        ld_tens = 4'd1; ld_ones = 4'd2; allow_start = 1'b1;
        exp(12, "pre_load_idle", 4'h0, 4'h0, 4'b0000);
        exp(13, "load_12",       4'h1, 4'h2, 4'b1000);
        exp(16, "hold_12",       4'h1, 4'h2, 4'b1000);
        exp(17, "dec_11",        4'h1, 4'h1, 4'b1000);
        exp(21, "dec_10",        4'h1, 4'h0, 4'b1000);
        exp(25, "borrow_09",     4'h0, 4'h9, 4'b1000);
        exp(60, "last_01",       4'h0, 4'h1, 4'b1000);
        exp(61, "zero_done",     4'h0, 4'h0, 4'b0011);
        exp(62, "alarm_on",      4'h0, 4'h0, 4'b0001);
        exp(68, "alarm_last",    4'h0, 4'h0, 4'b0001);
        exp(69, "alarm_off",     4'h0, 4'h0, 4'b0000);
        go(20);
        allow_start = 1'b0;
        // pause / resume keeps the partial second
        go(75);
        ld_tens = 4'd0; ld_ones = 4'd5; allow_start = 1'b1;
        exp(82,  "pz_dec_04",   4'h0, 4'h4, 4'b1000);
        exp(83,  "pz_pre",      4'h0, 4'h4, 4'b1000);
        exp(84,  "pz_paused",   4'h0, 4'h4, 4'b0100);
        exp(95,  "pz_frozen",   4'h0, 4'h4, 4'b0100);
        exp(103, "pz_frozen2",  4'h0, 4'h4, 4'b0100);
        exp(104, "pz_resumed",  4'h0, 4'h4, 4'b1000);
        exp(105, "pz_hold",     4'h0, 4'h4, 4'b1000);
        exp(106, "pz_dec_03",   4'h0, 4'h3, 4'b1000);
        exp(111, "pz_cancel",   4'h0, 4'h0, 4'b0000);
        go(83);  pause_req = 1'b1;
        go(84);  pause_req = 1'b0;
        go(85);  allow_start = 1'b0;
        go(103); pause_req = 1'b1;
        go(104); pause_req = 1'b0;
        go(110); cancel = 1'b1;
        go(111); cancel = 1'b0;
        // invalid and zero loads are ignored
        go(115);
        ld_tens = 4'd0; ld_ones = 4'd0; allow_start = 1'b1;
        exp(118, "zero_ignored",   4'h0, 4'h0, 4'b0000);
        exp(120, "zero_ignored2",  4'h0, 4'h0, 4'b0000);
        exp(127, "inval_ignored",  4'h0, 4'h0, 4'b0000);
        exp(129, "inval_ignored2", 4'h0, 4'h0, 4'b0000);
        exp(136, "load_03",        4'h0, 4'h3, 4'b1000);
        go(121); allow_start = 1'b0;
        go(124); ld_tens = 4'd1; ld_ones = 4'hA; allow_start = 1'b1;
        go(130); allow_start = 1'b0;
        go(133); ld_tens = 4'd0; ld_ones = 4'd3; allow_start = 1'b1;
        go(137); allow_start = 1'b0;
        // cancel beats a simultaneous start
        go(140);
        ld_tens = 4'd0; ld_ones = 4'd7; allow_start = 1'b1;
        exp(143, "restart_07",   4'h0, 4'h7, 4'b1000);
        exp(146, "run_07",       4'h0, 4'h7, 4'b1000);
        exp(147, "cancel_wins",  4'h0, 4'h0, 4'b0000);
        exp(152, "start_lost",   4'h0, 4'h0, 4'b0000);
        go(143); allow_start = 1'b0;
        go(144); ld_tens = 4'd0; ld_ones = 4'd8; allow_start = 1'b1;
        go(146); cancel = 1'b1;
        go(147); cancel = 1'b0;
        // restart while alarming
        go(155); allow_start = 1'b0;
        go(158);
        ld_tens = 4'd0; ld_ones = 4'd1; allow_start = 1'b1;
        exp(161, "load_01",       4'h0, 4'h1, 4'b1000);
        exp(165, "done_01",       4'h0, 4'h0, 4'b0011);
        exp(167, "alarm_01",      4'h0, 4'h0, 4'b0001);
        exp(168, "alarm_restart", 4'h2, 4'h0, 4'b1000);
        go(162); allow_start = 1'b0;
        go(165); ld_tens = 4'd2; ld_ones = 4'd0; allow_start = 1'b1;
        // asynchronous reset mid-run with allow_start held high
        go(170);
        exp(171, "async_reset",   4'h0, 4'h0, 4'b0000);
        exp(177, "no_stale_start", 4'h0, 4'h0, 4'b0000);
        exp(180, "no_stale_start2", 4'h0, 4'h0, 4'b0000);
        exp(186, "pre_rearm",     4'h0, 4'h0, 4'b0000);
        exp(187, "rearm_load_04", 4'h0, 4'h4, 4'b1000);
        exp(191, "final_cancel",  4'h0, 4'h0, 4'b0000);
        @(posedge clk);
        #2 reset = 1'b1;
        go(174); reset = 1'b0;
        go(181); allow_start = 1'b0; ld_tens = 4'd0; ld_ones = 4'd4;
        go(184); allow_start = 1'b1;
        go(190); cancel = 1'b1;
        go(191); cancel = 1'b0;
        go(200);
        n_chk++;
        if (done_cnt != 2) begin
            n_fail++;
            $display("FAIL done_pulses: got %0d pulses, expected 2", done_cnt);
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
